piso_reg: RTL

- Parallel-in serial-out serializer: the transmit end of the team's 8-bit serial link.
- Accepts a DATA_W-bit word on a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Drives a bit strobe (sout_en) that connects directly to the receiver's en input, with sout connected to its din.
- After DATA_W strobes, the receiver's parallel output equals the transmitted word.
- A one-entry holding buffer allows gap-free back-to-back words.

---
 rtl/toyup_serial_pkg.sv | 27 ++
 rtl/piso_hold_buf.sv | 40 ++++
 rtl/piso_reg.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/toyup_serial_pkg.sv
// Shared definitions for the 8-bit serial link.
// Holds the default word width, the serializer state encoding and the even
// parity helper (also meant for a future checking receiver).
// Optional feature macro used by link blocks: PISO_PARITY_EN.
package toyup_serial_pkg;

    localparam int unsigned SERIAL_DATA_W = 8;

    // Widest word the parity helper accepts; callers zero-extend to this width.
    localparam int unsigned PAR_MAX_W = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        STATE_IDLE   = ST_IDLE,
        STATE_SHIFT  = ST_SHIFT,
        STATE_PARITY = ST_PARITY
    } piso_state_e;

    // Even parity bit: XOR of all word bits (zero extension does not change it).
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] i_word);
        return ^i_word;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding buffer for the serializer.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   i_push        - write i_data, sets full
//   i_pop         - drop the stored word (push wins if both are high)
//   i_data        - word to store
//   o_data        - stored word
//   o_full        - buffer occupied
module piso_hold_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full
);

    logic [DATA_W-1:0] r_data;
    logic              r_full;

    // Storage and occupancy flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_push) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/piso_reg.sv
// Parallel-in serial-out serializer (transmit end of the serial link).
// Accepts a word on a valid/ready handshake and shifts it out MSB first,
// one bit per clock, with a bit strobe for the receiver. A one-entry hold
// buffer lets consecutive words go out without a gap.
// Optional feature: define PISO_PARITY_EN to append an even parity bit
// to every frame (frame becomes DATA_W+1 bits, done moves to the parity bit).
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - synchronous active-low reset
//   din_valid  - producer has a word on din
//   din        - parallel word to transmit
//   din_ready  - word can be accepted this cycle
//   sout       - serial data bit, MSB first
//   sout_en    - sout carries a valid bit
//   busy       - shifting, or hold buffer occupied
//   done       - pulse on the final bit of a frame
module piso_reg
    import toyup_serial_pkg::*;
#(
    parameter int unsigned DATA_W = SERIAL_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    piso_state_e       r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sout_en;
    logic              r_done;
    logic              r_rdy_en;
`ifdef PISO_PARITY_EN
    logic              r_par;
`endif

    logic              w_hold_full;
    logic [DATA_W-1:0] w_hold_data;
    logic              w_push;
    logic              w_frame_end;
    logic              w_load;
    logic              w_load_hold;
    logic              w_hold_push;
    logic [DATA_W-1:0] w_load_word;

    // Ready is held low for the cycle right after reset is sampled.
    assign din_ready = r_rdy_en && !w_hold_full;
    assign w_push    = din_valid && din_ready;

    // Points at which the shift register may take a new word.
`ifdef PISO_PARITY_EN
    assign w_frame_end = (r_state == STATE_IDLE) || (r_state == STATE_PARITY);
`else
    assign w_frame_end = (r_state == STATE_IDLE) ||
                         ((r_state == STATE_SHIFT) && (r_cnt == '0));
`endif

    // The held word always goes first; a direct load only happens when hold is empty.
    assign w_load      = w_frame_end && (w_hold_full || w_push);
    assign w_load_hold = w_load && w_hold_full;
    assign w_load_word = w_hold_full ? w_hold_data : din;
    assign w_hold_push = w_push && !(w_load && !w_hold_full);

    piso_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_hold_push),
        .i_pop  (w_load_hold),
        .i_data (din),
        .o_data (w_hold_data),
        .o_full (w_hold_full)
    );

    // FSM, bit counter and shift register; sout is the register MSB.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= STATE_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_sout_en <= 1'b0;
            r_done    <= 1'b0;
            r_rdy_en  <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_rdy_en <= 1'b1;
            if (w_load) begin
                r_state   <= STATE_SHIFT;
                r_shift   <= w_load_word;
                r_cnt     <= CNT_W'(DATA_W - 1);
                r_sout_en <= 1'b1;
                r_done    <= 1'b0;
`ifdef PISO_PARITY_EN
                r_par     <= even_parity(PAR_MAX_W'(w_load_word));
`endif
            end else begin
                case (r_state)
                    STATE_SHIFT: begin
                        if (r_cnt != '0) begin
                            r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                            r_cnt     <= r_cnt - CNT_W'(1);
                            r_sout_en <= 1'b1;
`ifdef PISO_PARITY_EN
                            r_done    <= 1'b0;
`else
                            r_done    <= (r_cnt == CNT_W'(1));
`endif
                        end else begin
`ifdef PISO_PARITY_EN
                            // Parity bit rides in the MSB so sout stays a plain register bit.
                            r_state   <= STATE_PARITY;
                            r_shift   <= {r_par, {(DATA_W-1){1'b0}}};
                            r_sout_en <= 1'b1;
                            r_done    <= 1'b1;
`else
                            r_state   <= STATE_IDLE;
                            r_shift   <= '0;
                            r_sout_en <= 1'b0;
                            r_done    <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        r_state   <= STATE_IDLE;
                        r_shift   <= '0;
                        r_cnt     <= '0;
                        r_sout_en <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sout    = r_shift[DATA_W-1];
    assign sout_en = r_sout_en;
    assign done    = r_done;
    assign busy    = (r_state != STATE_IDLE) || w_hold_full;

endmodule
